// File: rtl/regbus_bridge.sv
// Byte-stream to register-bus bridge: decodes read/write commands from the host
// link, issues one register access, and streams back a status/data response.
module regbus_bridge #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxdata,
  input  logic        rxvalid,
  output logic        rxready,
  output logic [7:0]  txdata,
  output logic        txvalid,
  input  logic        txready,
  output logic        regreq,
  output logic        regwr,
  output logic [11:0] regaddr,
  output logic [31:0] regwdata,
  input  logic        regack,
  input  logic        regerr,
  input  logic [31:0] regrdata,
  output logic [2:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, ADDRH, ADDRL, WDATA, REQ, WAIT, RESP} state_t;

  // Handshakes: a byte moves on rx when rxvalid && rxready, on tx when
  // txvalid && txready; txvalid/txdata never change while txready is low.
  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [1:0]      wcnt;
  logic [39:0]     resp_sr;
  logic [2:0]      resp_len;
  logic            rx_fire, tx_fire, tout, cmd_ok;

  assign rx_fire   = rxvalid && rxready;
  assign tx_fire   = txvalid && txready;
  assign tout      = (cnt == CW'(TIMEOUT - 1));
  assign cmd_ok    = (rxdata == 8'h01) || (rxdata == 8'h02);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rxready   = 1'b0;
    txvalid   = 1'b0;
    regreq    = 1'b0;
    txdata    = resp_sr[39:32];
    case (state)
      IDLE: begin
        rxready = !rst;
        if (rx_fire) state_nxt = cmd_ok ? ADDRH : RESP;
      end
      ADDRH: begin
        rxready = !rst;
        if (rx_fire) state_nxt = ADDRL;
      end
      ADDRL: begin
        rxready = !rst;
        if (rx_fire) state_nxt = regwr ? WDATA : REQ;
      end
      WDATA: begin
        rxready = !rst;
        if (rx_fire && wcnt == 2'd3) state_nxt = REQ;
      end
      REQ: begin
        regreq    = !rst;
        state_nxt = WAIT;
      end
      WAIT: begin
        // An ack in the final counted cycle still takes priority over timeout.
        if (regack || tout) state_nxt = RESP;
      end
      RESP: begin
        txvalid = !rst;
        if (tx_fire && resp_len == 3'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwr    <= 1'b0;
      regaddr  <= '0;
      regwdata <= '0;
      wcnt     <= '0;
      cnt      <= '0;
      resp_sr  <= '0;
      resp_len <= '0;
    end else begin
      // Counter only runs while staying in WAIT, so it stops at TIMEOUT-1.
      cnt <= (state == WAIT && state_nxt == WAIT) ? cnt + CW'(1) : '0;
      case (state)
        IDLE: if (rx_fire) begin
          if (cmd_ok) begin
            regwr    <= (rxdata == 8'h02);
            regwdata <= '0;
            wcnt     <= '0;
          end else begin
            resp_sr  <= {8'hEE, 32'h0};
            resp_len <= 3'd1;
          end
        end
        ADDRH: if (rx_fire) regaddr[11:8] <= rxdata[3:0];
        ADDRL: if (rx_fire) regaddr[7:0]  <= rxdata;
        WDATA: if (rx_fire) begin
          regwdata <= {regwdata[23:0], rxdata};
          wcnt     <= wcnt + 2'd1;
        end
        WAIT: begin
          if (regack) begin
            if (regerr) begin
              resp_sr  <= {8'h01, 32'h0};
              resp_len <= 3'd1;
            end else if (regwr) begin
              resp_sr  <= {8'h00, 32'h0};
              resp_len <= 3'd1;
            end else begin
              resp_sr  <= {8'h00, regrdata};
              resp_len <= 3'd5;
            end
          end else if (tout) begin
            resp_sr  <= {8'hEF, 32'h0};
            resp_len <= 3'd1;
          end
        end
        RESP: if (tx_fire) begin
          resp_sr  <= {resp_sr[31:0], 8'h00};
          resp_len <= resp_len - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regbus_bridge.sv
// Bench for regbus_bridge: a register-memory responder plus a response model
// that predicts the host-link byte stream from command, ack delay and error.
module tb_regbus_bridge;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxdata;
  logic        rxvalid;
  logic        rxready;
  logic [7:0]  txdata;
  logic        txvalid;
  logic        txready = 1'b0;
  logic        regreq;
  logic        regwr;
  logic [11:0] regaddr;
  logic [31:0] regwdata;
  logic        regack;
  logic        regerr;
  logic [31:0] regrdata;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int req_cnt = 0;
  int tx_mode = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] mem [logic [11:0]];

  regbus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rxdata(rxdata), .rxvalid(rxvalid), .rxready(rxready),
    .txdata(txdata), .txvalid(txvalid), .txready(txready), .regreq(regreq),
    .regwr(regwr), .regaddr(regaddr), .regwdata(regwdata), .regack(regack),
    .regerr(regerr), .regrdata(regrdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // tx sink: 0 always ready, 1 toggling, 2 random, 3 stalled
  always @(posedge clk) begin
    #2;
    case (tx_mode)
      0:       txready = 1'b1;
      1:       txready = ~txready;
      2:       txready = 1'($urandom_range(0, 1));
      default: txready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && txvalid && txready) got_q.push_back(txdata);
    if (!rst && regreq) req_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n;
    n = $urandom_range(0, max_gap);
    repeat (n) begin
      rxvalid = 1'b0;
      rxdata  = 8'($urandom);
      tick();
    end
    rxvalid = 1'b1;
    rxdata  = b;
    for (int i = 0; i < 200; i++) begin
      if (rxready) begin
        tick();
        rxvalid = 1'b0;
        return;
      end
      tick();
    end
    checks++; failures++;
    $display("FAIL send_byte: byte %02h not accepted within 200 cycles", b);
    rxvalid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // One full transaction; d = cycles after the regreq cycle that regack rises (<0: never).
  task automatic run_txn(input bit wr, input logic [11:0] addr, input logic [3:0] junk,
                         input logic [31:0] wdata, input int d, input bit err, input int gap);
    logic [31:0] rd;
    logic [7:0]  pd;
    int rc, last, req0, hold_bad, quiet_bad, stab_bad;
    bit acked, pv, pr;
    got_q.delete();
    exp_q.delete();
    rd = mem.exists(addr) ? mem[addr] : 32'h0;
    acked = (d >= 1 && d <= TO);
    if (!acked) exp_q.push_back(8'hEF);
    else if (err) exp_q.push_back(8'h01);
    else begin
      exp_q.push_back(8'h00);
      if (wr) mem[addr] = wdata;
      else for (int i = 0; i < 4; i++) exp_q.push_back(rd[31-8*i -: 8]);
    end
    req0 = req_cnt;
    send_byte(wr ? 8'h02 : 8'h01, gap);
    send_byte({junk, addr[11:8]}, gap);
    send_byte(addr[7:0], gap);
    if (wr) for (int i = 0; i < 4; i++) send_byte(wdata[31-8*i -: 8], gap);

    checks++;
    if (regreq !== 1'b1 || regwr !== wr || regaddr !== addr) begin
      failures++;
      $display("FAIL req_fields: regreq=%b regwr=%b regaddr=%03h, required 1 %b %03h",
               regreq, regwr, regaddr, wr, addr);
    end
    if (wr) begin
      checks++;
      if (regwdata !== wdata) begin
        failures++;
        $display("FAIL req_wdata: regwdata=%08h required %08h", regwdata, wdata);
      end
    end

    rc = acked ? d + 1 : TO + 1;
    last = (d + 1 > rc) ? d + 1 : rc;
    quiet_bad = 0;
    stab_bad = 0;
    for (int c = 1; c <= last; c++) begin
      tick();
      if (c == d) begin
        regack = 1'b1;
        regerr = err;
        regrdata = err ? $urandom : rd;
      end else begin
        regack = 1'b0;
      end
      if (c < rc) begin
        if (regreq !== 1'b0 || txvalid !== 1'b0) quiet_bad++;
        if (regaddr !== addr || regwr !== wr || (wr && regwdata !== wdata)) stab_bad++;
      end
      if (c == rc) begin
        checks++;
        if (txvalid !== 1'b1) begin
          failures++;
          $display("FAIL resp_latency: txvalid=%b at cycle %0d after regreq, required 1", txvalid, rc);
        end
      end
    end
    regack = 1'b0;
    checks++;
    if (quiet_bad != 0) begin
      failures++;
      $display("FAIL wait_quiet: %0d cycles with regreq/txvalid high, required 0", quiet_bad);
    end
    checks++;
    if (stab_bad != 0) begin
      failures++;
      $display("FAIL req_stable: %0d cycles with changed access fields, required 0", stab_bad);
    end

    pv = 1'b0; pr = 1'b0; pd = 8'h00; hold_bad = 0;
    for (int c = 0; c < 300 && got_q.size() < exp_q.size(); c++) begin
      @(negedge clk); #1;
      if (pv && !pr && (txvalid !== 1'b1 || txdata !== pd)) hold_bad++;
      pv = txvalid; pr = txready; pd = txdata;
      tick();
    end
    repeat (4) tick();

    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL resp_count: got %0d bytes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL resp_byte[%0d]: got %02h required %02h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (hold_bad != 0) begin
      failures++;
      $display("FAIL tx_hold: %0d stalled cycles changed txvalid/txdata, required 0", hold_bad);
    end
    checks++;
    if (req_cnt - req0 != 1) begin
      failures++;
      $display("FAIL req_pulses: %0d regreq cycles, required 1", req_cnt - req0);
    end
    checks++;
    if (txvalid !== 1'b0 || rxready !== 1'b1) begin
      failures++;
      $display("FAIL back_to_idle: txvalid=%b rxready=%b, required 0 1", txvalid, rxready);
    end
  endtask

  task automatic expect_silence(input string name, input int cycles, input int req0);
    int bad;
    bad = 0;
    repeat (cycles) begin
      tick();
      if (txvalid !== 1'b0 || regreq !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || got_q.size() != 0 || req_cnt != req0) begin
      failures++;
      $display("FAIL %s: busy_cycles=%0d tx_bytes=%0d extra_req=%0d, required 0 0 0",
               name, bad, got_q.size(), req_cnt - req0);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (rxready !== 1'b0 || txvalid !== 1'b0 || regreq !== 1'b0 || regwr !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: rxready=%b txvalid=%b regreq=%b regwr=%b, required 0 0 0 0",
               rxready, txvalid, regreq, regwr);
    end
    checks++;
    if (regaddr !== 12'h0 || regwdata !== 32'h0 || txdata !== 8'h0) begin
      failures++;
      $display("FAIL reset_data: regaddr=%03h regwdata=%08h txdata=%02h, required 0 0 0",
               regaddr, regwdata, txdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rxready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: rxready=%b required 1", rxready);
    end
  endtask

  task automatic test_write();
    tx_mode = 0;
    run_txn(1'b1, 12'h000, 4'h0, 32'h0000_0002, 3, 1'b0, 0);
  endtask

  task automatic test_read();
    tx_mode = 0;
    run_txn(1'b0, 12'h008, 4'h0, 32'h0, 2, 1'b0, 0);
    run_txn(1'b0, 12'h000, 4'h0, 32'h0, 1, 1'b0, 2);
  endtask

  task automatic test_errors();
    tx_mode = 2;
    run_txn(1'b1, 12'h008, 4'h5, 32'hDEAD_BEEF, 1, 1'b1, 1);
    run_txn(1'b0, 12'h008, 4'hA, 32'h0, 4, 1'b1, 1);
    run_txn(1'b0, 12'h008, 4'h3, 32'h0, 2, 1'b0, 1);
  endtask

  task automatic test_bad_cmd();
    int req0;
    logic [7:0] b;
    tx_mode = 0;
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? 8'h7F : 8'($urandom_range(3, 255));
      got_q.delete();
      req0 = req_cnt;
      send_byte(b, 1);
      checks++;
      if (txvalid !== 1'b1 || txdata !== 8'hEE) begin
        failures++;
        $display("FAIL bad_cmd_resp: cmd %02h gave txvalid=%b txdata=%02h, required 1 EE", b, txvalid, txdata);
      end
      repeat (4) tick();
      checks++;
      if (got_q.size() != 1 || req_cnt != req0) begin
        failures++;
        $display("FAIL bad_cmd_stream: tx_bytes=%0d regreq_cycles=%0d, required 1 0",
                 got_q.size(), req_cnt - req0);
      end
    end
    run_txn(1'b0, 12'h000, 4'h0, 32'h0, 2, 1'b0, 0);
  endtask

  task automatic test_timeout();
    tx_mode = 0;
    run_txn(1'b0, 12'h123, 4'h0, 32'h0, -1, 1'b0, 0);
    got_q.delete();
    regack = 1'b1;
    regerr = 1'b0;
    tick();
    regack = 1'b0;
    expect_silence("late_ack", 10, req_cnt);
    run_txn(1'b1, 12'h456, 4'h0, 32'h1234_5678, TO, 1'b0, 0);
    run_txn(1'b0, 12'h456, 4'h0, 32'h0, TO, 1'b0, 0);
    run_txn(1'b0, 12'h456, 4'h0, 32'h0, TO + 1, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    tx_mode = 1;
    mem[12'h2C4] = 32'h8142_C3E7;
    run_txn(1'b0, 12'h2C4, 4'h9, 32'h0, 2, 1'b0, 0);
    tx_mode = 2;
    run_txn(1'b0, 12'h2C4, 4'h1, 32'h0, 3, 1'b0, 2);
  endtask

  task automatic test_reset_wait();
    int req0;
    tx_mode = 0;
    got_q.delete();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    tick();
    tick();
    req0 = req_cnt;
    pulse_reset();
    checks++;
    if (rxready !== 1'b1 || txvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_wait_release: rxready=%b txvalid=%b, required 1 0", rxready, txvalid);
    end
    regack = 1'b1;
    regrdata = 32'hFFFF_FFFF;
    tick();
    regack = 1'b0;
    expect_silence("reset_wait_quiet", 20, req0);
    run_txn(1'b0, 12'h008, 4'h0, 32'h0, 2, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    int req0;
    tx_mode = 0;
    got_q.delete();
    req0 = req_cnt;
    send_byte(8'h02, 0);
    send_byte(8'h0A, 0);
    send_byte(8'h11, 0);
    pulse_reset();
    expect_silence("reset_mid_quiet", 6, req0);
    run_txn(1'b1, 12'hA11, 4'h0, 32'hCAFE_F00D, 2, 1'b0, 1);
    tx_mode = 3;
    got_q.delete();
    send_byte(8'h55, 0);
    repeat (3) tick();
    checks++;
    if (txvalid !== 1'b1 || txdata !== 8'hEE) begin
      failures++;
      $display("FAIL stalled_resp: txvalid=%b txdata=%02h, required 1 EE", txvalid, txdata);
    end
    req0 = req_cnt;
    pulse_reset();
    tx_mode = 0;
    expect_silence("reset_resp_quiet", 8, req0);
    run_txn(1'b0, 12'hA11, 4'h0, 32'h0, 1, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [11:0] pool [8];
    bit wr, err;
    int d;
    for (int i = 0; i < 8; i++) pool[i] = 12'($urandom);
    for (int n = 0; n < 25; n++) begin
      tx_mode = $urandom_range(0, 2);
      wr  = 1'($urandom_range(0, 1));
      err = ($urandom_range(0, 5) == 0);
      d   = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 6);
      run_txn(wr, pool[$urandom_range(0, 7)], 4'($urandom), $urandom, d, err, $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b1;
    rxvalid = 1'b0;
    rxdata = 8'h00;
    regack = 1'b0;
    regerr = 1'b0;
    regrdata = 32'h0;
    mem[12'h008] = 32'h0000_00A5;
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_bad_cmd();
    test_timeout();
    test_backpressure();
    test_reset_wait();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
